qed_replay_buffer: RTL and testbench
====================================

Name: qed_replay_buffer

Overview:
- Stage directly upstream of qed_decoder in the QED fetch path.
- Captures original instructions from the IFU while passing them downstream.
- On request, or when its store is full, it stalls fetch and replays the stored instructions in order as duplicates.
- Its registered output drives ifu_qed_instruction on the decoder.

Parameters:
- DEPTH, 4, number of original instructions buffered; power of two, 2..16.
- AW, $clog2(DEPTH), pointer width; count width is AW+1.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- qed_ena  input  1  QED enable; when 0 the block is a 1-cycle pass-through with no buffering.
- exec_dup  input  1  request to enter duplicate mode; sampled every cycle.
- stall  input  1  downstream pipeline stall; freezes the output and all state.
- ifu_instruction  input  32  instruction from IFU.
- ifu_valid  input  1  ifu_instruction valid.
- qed_instruction  output  32  to qed_decoder ifu_qed_instruction.
- qed_valid  output  1  qed_instruction valid.
- qed_is_dup  output  1  current output is a replayed duplicate.
- fetch_stall  output  1  tells IFU to hold its current instruction.
- buf_count  output  AW+1  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - qed_instruction=32'h00000013 (NOP); qed_valid=0; qed_is_dup=0; fetch_stall=0; buf_count=0.
  - FSM=ORIG; FIFO pointers=0.
- FSM states ORIG and DUP; the state register is 1 bit.
- ORIG, qed_ena=1:
  - On ifu_valid & !stall: register ifu_instruction to output next cycle (qed_valid=1, qed_is_dup=0) and push it into the FIFO.
  - fetch_stall=0 while count<DEPTH.
- ORIG -> DUP at the end of a cycle where !stall and either:
  - exec_dup=1 and count (after this cycle's push) >0, or
  - count reaches DEPTH.
- DUP:
  - fetch_stall=1 combinationally from state; IFU instructions are ignored.
  - Each !stall cycle pops the head; output = popped word with qed_valid=1, qed_is_dup=1.
  - Replay order matches capture order exactly.
- DUP -> ORIG on the cycle the last entry pops (count 1->0); fetch_stall drops the following cycle.
- exec_dup is ignored in DUP. exec_dup with count==0 in ORIG has no effect.
- Full: in ORIG with count==DEPTH, fetch_stall=1 and no push. This state is transient because the transition to DUP is forced.
- stall=1: output registers, FIFO, count and FSM all hold; qed_valid is held unchanged.
- ORIG with no valid input: qed_valid=0, qed_instruction=NOP, qed_is_dup=0.
- qed_ena=0:
  - Pass-through with 1-cycle latency; no push; qed_is_dup=0; fetch_stall=0.
  - Deasserting qed_ena in DUP is honoured only after the drain completes; the FIFO is never flushed except by reset.
- Simultaneous push of the DEPTH-th entry and exec_dup: the entry is pushed, then DUP is entered with count=DEPTH.
- Reset mid-replay: everything returns to reset values; buffered entries are discarded.
- Pointer wrap modulo DEPTH; count is never negative and never exceeds DEPTH.

Optional Feature:
- Macro QED_REPLAY_NOP_FILTER_EN.
- Defined:
  - Valid instructions equal to 32'h00000013 are forwarded in ORIG but not pushed.
  - The forced-DUP and exec_dup checks use the post-filter count.
- Undefined: every valid instruction is pushed.

Decomposition:
- Package qed_pkg:
  - QED_NOP constant (32'h00000013).
  - State typedef (QED_ORIG, QED_DUP).
  - Opcode localparams shared with qed_decoder.
- One sub-module, qed_sync_fifo:
  - Parameterised DEPTH/width 32; async active-low reset.
  - Ports push, pop, wdata, rdata, count, full, empty.
  - rdata is the combinational head.
- FSM, output register and stall/enable gating stay in qed_replay_buffer.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-cycle -> outputs immediately NOP/0/0/0, buf_count=0.
  - Release, then feed 32'h00A00093 -> qed_instruction=32'h00A00093 next cycle, qed_is_dup=0, buf_count=1.
- Forced replay: DEPTH=4, feed A,B,C,D consecutively -> fetch_stall=1 the cycle after D; outputs A,B,C,D with qed_is_dup=1 on 4 consecutive cycles; fetch_stall=0 after; buf_count=0.
- Early replay: feed A,B; assert exec_dup with C -> C pushed; replay A,B,C; exec_dup pulses during DUP have no effect.
- Stall: assert stall for 3 cycles mid-replay after A output -> qed_instruction holds A, buf_count unchanged; B follows on release.
- Pass-through: qed_ena=0, feed 10 instructions with exec_dup=1 -> never dup, fetch_stall=0, buf_count=0, latency 1.
- NOP filter (macro defined): feed A,NOP,B,C,D -> NOP forwarded but not buffered; replay A,B,C,D.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared QED definitions: NOP encoding, replay FSM state and opcodes common with qed_decoder.
package qed_pkg;

    localparam logic [31:0] QED_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

    typedef enum logic {
        QED_ORIG = 1'b0,
        QED_DUP  = 1'b1
    } qed_state_t;

    function automatic logic is_qed_nop(input logic [31:0] insn);
        return insn == QED_NOP;
    endfunction

endpackage

// File: rtl/qed_sync_fifo.sv
// Synchronous FIFO with combinational head; push when full and pop when empty are ignored.
module qed_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/qed_replay_buffer.sv
// QED replay stage: captures original instructions, then replays them as duplicates while stalling fetch.
// Optional macro QED_REPLAY_NOP_FILTER_EN: forward NOPs in ORIG without buffering them.
module qed_replay_buffer
    import qed_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          qed_ena,
    input  logic          exec_dup,
    input  logic          stall,
    input  logic [31:0]   ifu_instruction,
    input  logic          ifu_valid,
    output logic [31:0]   qed_instruction,
    output logic          qed_valid,
    output logic          qed_is_dup,
    output logic          fetch_stall,
    output logic [AW:0]   buf_count
);

    localparam int unsigned CW = AW + 1;

    qed_state_t  state, state_d;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        dup_d;
    logic        push;
    logic        pop;
    logic        accept;
    logic        drop_c;
    logic [AW:0] cnt_after;
    logic [31:0] rdata;
    logic        full;
    logic        empty;

    qed_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (ifu_instruction),
        .rdata (rdata),
        .count (buf_count),
        .full  (full),
        .empty (empty)
    );

`ifdef QED_REPLAY_NOP_FILTER_EN
    assign drop_c = is_qed_nop(ifu_instruction);
`else
    assign drop_c = 1'b0;
`endif

    // IFU must hold while replaying or while the store is full.
    assign fetch_stall = (state == QED_DUP) | full;

    // Next state, FIFO controls and next output values.
    always_comb begin
        state_d   = state;
        instr_d   = qed_instruction;
        valid_d   = qed_valid;
        dup_d     = qed_is_dup;
        push      = 1'b0;
        pop       = 1'b0;
        accept    = 1'b0;
        cnt_after = buf_count;
        if (!stall) begin
            if (state == QED_DUP) begin
                pop     = ~empty;
                instr_d = empty ? QED_NOP : rdata;
                valid_d = ~empty;
                dup_d   = ~empty;
                if (buf_count <= CW'(1)) state_d = QED_ORIG;
            end else begin
                accept    = ifu_valid & ~(qed_ena & full);
                instr_d   = accept ? ifu_instruction : QED_NOP;
                valid_d   = accept;
                dup_d     = 1'b0;
                push      = qed_ena & accept & ~drop_c;
                cnt_after = buf_count + CW'(push);
                if (qed_ena && ((exec_dup && cnt_after != '0) || cnt_after == CW'(DEPTH)))
                    state_d = QED_DUP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= QED_ORIG;
            qed_instruction <= QED_NOP;
            qed_valid       <= 1'b0;
            qed_is_dup      <= 1'b0;
        end else begin
            state           <= state_d;
            qed_instruction <= instr_d;
            qed_valid       <= valid_d;
            qed_is_dup      <= dup_d;
        end
    end

endmodule

// File: tb/tb_qed_replay_buffer.sv
// Directed bench for qed_replay_buffer (DEPTH=4) with hand-computed expectations.
module tb_qed_replay_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        qed_ena;
    logic        exec_dup;
    logic        stall;
    logic [31:0] ifu_instruction;
    logic        ifu_valid;
    logic [31:0] qed_instruction;
    logic        qed_valid;
    logic        qed_is_dup;
    logic        fetch_stall;
    logic [AW:0] buf_count;

    int vectors = 0;
    int errors  = 0;

    qed_replay_buffer #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .qed_ena         (qed_ena),
        .exec_dup        (exec_dup),
        .stall           (stall),
        .ifu_instruction (ifu_instruction),
        .ifu_valid       (ifu_valid),
        .qed_instruction (qed_instruction),
        .qed_valid       (qed_valid),
        .qed_is_dup      (qed_is_dup),
        .fetch_stall     (fetch_stall),
        .buf_count       (buf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] insn, input logic v,
                             input logic d, input logic fs, input int cnt);
        chk({tag, ".insn"}, qed_instruction, insn);
        chk({tag, ".valid"}, 32'(qed_valid), 32'(v));
        chk({tag, ".dup"}, 32'(qed_is_dup), 32'(d));
        chk({tag, ".fstall"}, 32'(fetch_stall), 32'(fs));
        chk({tag, ".count"}, 32'(buf_count), 32'(cnt));
    endtask

    task automatic feed(input logic [31:0] insn);
        ifu_valid       = 1'b1;
        ifu_instruction = insn;
        tick();
    endtask

    logic [31:0] w [4];

    initial begin
        rst_n = 1'b0; qed_ena = 1'b0; exec_dup = 1'b0; stall = 1'b0;
        ifu_instruction = '0; ifu_valid = 1'b0;
        tick(); tick();
        check_out("reset", NOP, 0, 0, 0, 0);
        rst_n = 1'b1; qed_ena = 1'b1;

        // First capture, then an explicit single-entry replay.
        feed(32'h00A0_0093);
        check_out("first", 32'h00A0_0093, 1, 0, 0, 1);
        ifu_valid = 1'b0; tick();
        check_out("idle", NOP, 0, 0, 0, 1);
        exec_dup = 1'b1; tick();
        check_out("req_dup", NOP, 0, 0, 1, 1);
        exec_dup = 1'b0; tick();
        check_out("dup1", 32'h00A0_0093, 1, 1, 0, 0);

        // Forced replay on full; IFU words offered during replay are ignored.
        w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h3333_0003; w[3] = 32'h4444_0004;
        for (int i = 0; i < 4; i++) begin
            feed(w[i]);
            check_out("fcap", w[i], 1, 0, (i == 3) ? 1'b1 : 1'b0, i + 1);
        end
        ifu_instruction = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) ifu_valid = 1'b0;
            tick();
            check_out("frep", w[i], 1, 1, (i == 3) ? 1'b0 : 1'b1, 3 - i);
        end
        tick();
        check_out("fdone", NOP, 0, 0, 0, 0);

        // Early replay: exec_dup together with the third push, held through DUP.
        w[0] = 32'h0050_0113; w[1] = 32'h0060_0193; w[2] = 32'h0070_0213;
        feed(w[0]); feed(w[1]);
        exec_dup = 1'b1; feed(w[2]);
        check_out("ecap", w[2], 1, 0, 1, 3);
        ifu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("erep", w[i], 1, 1, (i == 2) ? 1'b0 : 1'b1, 2 - i);
        end
        tick();
        check_out("edup_empty", NOP, 0, 0, 0, 0);
        exec_dup = 1'b0;

        // Stall for three cycles after the first replayed word.
        w[0] = 32'hC000_0000; w[1] = 32'hC000_0001; w[2] = 32'hC000_0002; w[3] = 32'hC000_0003;
        for (int i = 0; i < 4; i++) feed(w[i]);
        ifu_valid = 1'b0; tick();
        check_out("srep0", w[0], 1, 1, 1, 3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("shold", w[0], 1, 1, 1, 3);
        end
        stall = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            check_out("srep", w[i], 1, 1, (i == 3) ? 1'b0 : 1'b1, 3 - i);
        end

        // Pass-through with exec_dup asserted.
        qed_ena = 1'b0; exec_dup = 1'b1;
        for (int i = 0; i < 10; i++) begin
            feed(32'h1000_0000 + 32'(i));
            check_out("pass", 32'h1000_0000 + 32'(i), 1, 0, 0, 0);
        end
        ifu_valid = 1'b0; tick();
        check_out("pass_idle", NOP, 0, 0, 0, 0);
        exec_dup = 1'b0;

        // Drain continues after qed_ena drops mid-replay.
        qed_ena = 1'b1;
        w[0] = 32'hE000_0000; w[1] = 32'hE000_0001; w[2] = 32'hE000_0002; w[3] = 32'hE000_0003;
        for (int i = 0; i < 4; i++) feed(w[i]);
        ifu_valid = 1'b0; qed_ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("ena_drain", w[i], 1, 1, (i == 3) ? 1'b0 : 1'b1, 3 - i);
        end

        // Asynchronous reset in the middle of a replay discards the buffer.
        qed_ena = 1'b1;
        for (int i = 0; i < 4; i++) feed(32'hF000_0000 + 32'(i));
        ifu_valid = 1'b0; tick();
        check_out("pre_rst", 32'hF000_0000, 1, 1, 1, 3);
        #3 rst_n = 1'b0;
        #1 check_out("mid_rst", NOP, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        feed(32'h0000_ABCD);
        check_out("post_rst", 32'h0000_ABCD, 1, 0, 0, 1);
        ifu_valid = 1'b0; exec_dup = 1'b1; tick();
        exec_dup = 1'b0; tick();
        check_out("post_rst_dup", 32'h0000_ABCD, 1, 1, 0, 0);

        // NOP handling: filtered when the macro is defined, buffered otherwise.
        w[0] = 32'hA000_000A; w[1] = 32'hB000_000B; w[2] = 32'hC000_000C; w[3] = 32'hD000_000D;
        feed(w[0]);
        feed(NOP);
`ifdef QED_REPLAY_NOP_FILTER_EN
        check_out("nop_fwd", NOP, 1, 0, 0, 1);
        for (int i = 1; i < 4; i++) feed(w[i]);
        check_out("nop_full", w[3], 1, 0, 1, 4);
`else
        check_out("nop_fwd", NOP, 1, 0, 0, 2);
        feed(w[1]); feed(w[2]);
        check_out("nop_full", w[2], 1, 0, 1, 4);
        w[3] = w[2]; w[2] = w[1]; w[1] = NOP;
`endif
        ifu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("nop_rep", w[i], 1, 1, (i == 3) ? 1'b0 : 1'b1, 3 - i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
